// File: rtl/muldiv_sequencer_if.sv
// Pipeline-side bundle for the multiply/divide sequencer, including the borrowed ALU path.
interface muldiv_sequencer_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        abort;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] alu_A;
    logic [31:0] alu_B;
    logic [3:0]  alu_op;
    logic [31:0] alu_out;

    // Pipeline/ALU side: issues ops, MTHI/MTLO writes and returns the ALU result.
    modport master (
        output start, op, A, B, abort, hi_we, lo_we, wdata, alu_out,
        input  busy, done, hi, lo, alu_A, alu_B, alu_op
    );

    // Sequencer side.
    modport slave (
        input  start, op, A, B, abort, hi_we, lo_we, wdata, alu_out,
        output busy, done, hi, lo, alu_A, alu_B, alu_op
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO. Uses the shared ALU for one
// add (shift-add multiply) or subtract (restoring divide) per iteration, 32 iterations per op.
module muldiv_sequencer #(
    parameter int unsigned WIDTH = 32
) (
    input logic             clk,
    input logic             rst,
    muldiv_sequencer_if.slave bus
);
    localparam logic [3:0] ALU_ADDU = 4'd0;
    localparam logic [3:0] ALU_SUBU = 4'd1;

    typedef enum logic [2:0] {StIdle, StPrep, StIter, StFix, StDone} state_t;

    state_t             state;
    logic               busy;
    logic               done;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic [1:0]         op_r;
    logic [WIDTH-1:0]   acc;   // product high half / partial remainder
    logic [WIDTH-1:0]   shr;   // multiplier -> product low half / dividend -> quotient
    logic [WIDTH-1:0]   mag;   // multiplicand / divisor magnitude
    logic               a_sign;
    logic               b_sign;
    logic               div_zero;
    logic [4:0]         cnt;

    logic               is_div;
    logic               signed_op;
    logic [WIDTH-1:0]   alu_a;
    logic [WIDTH-1:0]   alu_b;
    logic [3:0]         alu_op;
    logic [WIDTH-1:0]   rem_shift;
    logic               qbit;
    logic [WIDTH-1:0]   sum;
    logic               carry;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   quo_fix;

    function automatic logic [WIDTH-1:0] mag_of(input logic [WIDTH-1:0] x, input logic en);
        return (en && x[WIDTH-1]) ? -x : x;
    endfunction

    assign is_div    = op_r[1];
    assign signed_op = ~op_r[0];
    assign rem_shift = {acc[WIDTH-2:0], shr[WIDTH-1]};
    // rem33[32] set means the shifted remainder already exceeds any 32-bit divisor.
    assign qbit      = acc[WIDTH-1] | (rem_shift >= mag);
    assign sum       = shr[0] ? bus.alu_out : acc;
    assign carry     = shr[0] & (bus.alu_out < acc);
    assign prod      = {acc, shr};
    assign rem_fix   = (signed_op && a_sign) ? -acc : acc;
    assign quo_fix   = (signed_op && (a_sign ^ b_sign)) ? -shr : shr;

    // Drive the shared ALU only while iterating; otherwise present a harmless 0+0.
    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = ALU_ADDU;
        if (state == StIter) begin
            alu_b = mag;
            if (is_div) begin
                alu_a  = rem_shift;
                alu_op = ALU_SUBU;
            end else begin
                alu_a = acc;
            end
        end
    end

    // Sequencer FSM with registered busy/done and HI/LO ownership.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= StIdle;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            op_r     <= '0;
            acc      <= '0;
            shr      <= '0;
            mag      <= '0;
            a_sign   <= 1'b0;
            b_sign   <= 1'b0;
            div_zero <= 1'b0;
            cnt      <= '0;
        end else if (bus.abort) begin
            state <= StIdle;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            if (state == StIdle || state == StDone) begin
                if (bus.hi_we) hi <= bus.wdata;
                if (bus.lo_we) lo <= bus.wdata;
            end
            case (state)
                StIdle: begin
                    done <= 1'b0;
                    if (bus.start) begin
                        // Raw operands land in their iteration roles; PREP takes magnitudes.
                        op_r  <= bus.op;
                        shr   <= bus.op[1] ? bus.A : bus.B;
                        mag   <= bus.op[1] ? bus.B : bus.A;
                        state <= StPrep;
                        busy  <= 1'b1;
                    end
                end
                StPrep: begin
                    a_sign   <= is_div ? shr[WIDTH-1] : mag[WIDTH-1];
                    b_sign   <= is_div ? mag[WIDTH-1] : shr[WIDTH-1];
                    div_zero <= is_div && (mag == '0);
                    shr      <= mag_of(shr, signed_op);
                    mag      <= mag_of(mag, signed_op);
                    acc      <= '0;
                    cnt      <= '0;
                    state    <= StIter;
                end
                StIter: begin
                    if (is_div) begin
                        acc <= qbit ? bus.alu_out : rem_shift;
                        shr <= {shr[WIDTH-2:0], qbit};
                    end else begin
                        acc <= {carry, sum[WIDTH-1:1]};
                        shr <= {sum[0], shr[WIDTH-1:1]};
                    end
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) state <= StFix;
                end
                StFix: begin
                    if (!is_div) begin
                        {hi, lo} <= (signed_op && (a_sign ^ b_sign)) ? -prod : prod;
                    end else begin
                        // Divide by zero leaves the dividend in the remainder, i.e. hi = rs.
                        hi <= rem_fix;
                        lo <= div_zero ? '1 : quo_fix;
                    end
                    state <= StDone;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                StDone: begin
                    done  <= 1'b0;
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy   = busy;
    assign bus.done   = done;
    assign bus.hi     = hi;
    assign bus.lo     = lo;
    assign bus.alu_A  = alu_a;
    assign bus.alu_B  = alu_b;
    assign bus.alu_op = alu_op;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboarded bench for muldiv_sequencer with a behavioural shared ALU.
module tb_muldiv_sequencer;
    localparam logic [3:0] ALU_ADDU = 4'd0;
    localparam logic [3:0] ALU_SUBU = 4'd1;

    typedef struct {
        string       tag;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   errors   = 0;
    int   checks   = 0;
    int   done_cnt = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    muldiv_sequencer_if bus();

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Shared ALU model.
    always_comb bus.alu_out = (bus.alu_op == ALU_SUBU) ? bus.alu_A - bus.alu_B
                                                       : bus.alu_A + bus.alu_B;

    // Count done pulses away from the active edge.
    always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Architectural {hi, lo} for each op, from native arithmetic.
    function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      p;
        int          sa;
        int          sbv;
        int          q;
        int          r;
        logic [63:0] u;
        sa  = a;
        sbv = b;
        case (op)
            2'b00: begin
                p = longint'(sa) * longint'(sbv);
                return p;
            end
            2'b01: begin
                u = {32'b0, a} * {32'b0, b};
                return u;
            end
            2'b10: begin
                if (b == 32'h0) return {a, 32'hFFFFFFFF};
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
                q = sa / sbv;
                r = sa % sbv;
                return {r, q};
            end
            default: begin
                if (b == 32'h0) return {a, 32'hFFFFFFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Launch one op; optional stray start, abort, or busy-time MTHI/MTLO at given edge counts.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int restart_at, input int abort_at, input int we_at);
        logic [63:0] e;
        exp_t        x;
        logic [31:0] old_hi;
        logic [31:0] old_lo;
        int          n;
        int          d0;
        bit          seen;
        old_hi = bus.hi;
        old_lo = bus.lo;
        d0     = done_cnt;
        if (abort_at < 0) begin
            e     = ref_model(op, a, b);
            x.tag = $sformatf("op%0d_%h_%h", op, a, b);
            x.hi  = e[63:32];
            x.lo  = e[31:0];
            sb.push_back(x);
        end
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.A     = a;
        bus.B     = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("busy_after_start", bus.busy, 1);
        n    = 0;
        seen = 0;
        while (n < 60 && !seen) begin
            @(posedge clk);
            #1;
            n++;
            if (n == restart_at) begin
                bus.start = 1'b1;
                bus.op    = 2'b01;
                bus.A     = 32'h1;
                bus.B     = 32'h1;
            end
            if (n == restart_at + 1) bus.start = 1'b0;
            if (n == we_at) begin
                bus.hi_we = 1'b1;
                bus.lo_we = 1'b1;
                bus.wdata = 32'hDEADBEEF;
            end
            if (n == we_at + 1) begin
                bus.hi_we = 1'b0;
                bus.lo_we = 1'b0;
                check("hi_busy_write", bus.hi, old_hi);
                check("lo_busy_write", bus.lo, old_lo);
            end
            if (n == abort_at) bus.abort = 1'b1;
            if (n == abort_at + 1) begin
                bus.abort = 1'b0;
                check("abort_busy", bus.busy, 0);
                check("abort_done", bus.done, 0);
                check("abort_hi", bus.hi, old_hi);
                check("abort_lo", bus.lo, old_lo);
                return;
            end
            if (bus.done === 1'b1) seen = 1;
        end
        check("latency", n, 34);
        check("busy_at_done", bus.busy, 0);
        if (sb.size() == 0) begin
            check("scoreboard_nonempty", 0, 1);
        end else begin
            x = sb.pop_front();
            check({x.tag, "_hi"}, bus.hi, x.hi);
            check({x.tag, "_lo"}, bus.lo, x.lo);
        end
        @(posedge clk);
        #1;
        check("done_one_cycle", bus.done, 0);
        if (restart_at >= 0) begin
            repeat (40) @(posedge clk);
            #1;
            check("single_done", done_cnt - d0, 1);
            check("idle_after_restart", bus.busy, 0);
        end
    endtask

    initial begin
        int d0;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.A     = '0;
        bus.B     = '0;
        bus.abort = 1'b0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        bus.wdata = '0;
        rst       = 1'b1;
        @(posedge clk);
        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_hi", bus.hi, 0);
        check("rst_lo", bus.lo, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle_alu_a", bus.alu_A, 0);
        check("idle_alu_b", bus.alu_B, 0);
        check("idle_alu_op", bus.alu_op, ALU_ADDU);

        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, -1, -1);
        run_op(2'b00, 32'hFFFFFFFD, 32'd7, -1, -1, -1);
        run_op(2'b00, 32'h80000000, 32'h80000000, -1, -1, -1);
        run_op(2'b10, 32'hFFFFFFF9, 32'd2, -1, -1, -1);
        run_op(2'b11, 32'd100, 32'd7, -1, -1, -1);
        run_op(2'b11, 32'h1234, 32'h0, -1, -1, -1);
        run_op(2'b10, 32'hFFFFFF00, 32'h0, -1, -1, -1);
        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, -1, -1, -1);

        // MTHI in IDLE, then simultaneous MTHI/MTLO.
        @(negedge clk);
        bus.hi_we = 1'b1;
        bus.wdata = 32'hA5A5A5A5;
        @(posedge clk);
        #1;
        bus.hi_we = 1'b0;
        check("mthi_idle", bus.hi, 32'hA5A5A5A5);
        @(negedge clk);
        bus.hi_we = 1'b1;
        bus.lo_we = 1'b1;
        bus.wdata = 32'h0F0F1234;
        @(posedge clk);
        #1;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        check("both_hi", bus.hi, 32'h0F0F1234);
        check("both_lo", bus.lo, 32'h0F0F1234);

        run_op(2'b01, 32'd5, 32'd6, -1, -1, 5);
        run_op(2'b11, 32'd100, 32'd7, 10, -1, -1);

        d0 = done_cnt;
        run_op(2'b00, 32'd3, 32'd4, -1, 19, -1);
        repeat (40) @(posedge clk);
        #1;
        check("abort_no_done", done_cnt - d0, 0);

        // Abort together with start in IDLE: no launch.
        d0 = done_cnt;
        @(negedge clk);
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check("abort_start_busy", bus.busy, 0);
        repeat (40) @(posedge clk);
        #1;
        check("abort_start_no_done", done_cnt - d0, 0);

        for (int i = 0; i < 6; i++) begin
            run_op(2'(i % 4), $urandom, (i < 3) ? 32'($urandom_range(1, 1000)) : $urandom,
                   -1, -1, -1);
        end

        // Async reset mid-op clears HI/LO at once and suppresses done.
        d0 = done_cnt;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 2'b01;
        bus.A     = 32'd9;
        bus.B     = 32'd9;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (15) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst_busy", bus.busy, 0);
        check("arst_hi", bus.hi, 0);
        check("arst_lo", bus.lo, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("arst_no_done", done_cnt - d0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
